// File: rtl/h80cpu_uart_tx.sv
// H80CPU transmit-only UART on the IO bus.
// Byte FIFO feeding an 8N1 serializer; TXDATA/STATUS register pair.
package h80cpu_pkg;
  typedef logic [15:0] bus_addr_t;
  typedef logic [15:0] bus_data_t;
  typedef enum logic [1:0] {
    bus_cmd_read_w,
    bus_cmd_write_w,
    bus_cmd_read_b,
    bus_cmd_write_b
  } bus_cmd_t;
endpackage

module h80cpu_uart_tx
  import h80cpu_pkg::*;
#(
  parameter int CLK_FREQ   = 27000000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset,
  input  bus_addr_t addr,
  input  bus_cmd_t  cmd,
  input  logic      run,
  input  bus_data_t wr_data,
  output bus_data_t rd_data,
  output logic      done,
  output logic      uart_txp
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = $clog2(DIV);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);
  localparam logic [AW:0]   CNT_FULL  = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        r_state;
  state_t        w_state_n;
  logic [CW-1:0] r_baud, w_baud_n;
  logic [2:0]    r_bit, w_bit_n;
  logic [7:0]    r_shift, w_shift_n;
  logic          r_txp, w_txp_n;
  logic          r_done;
  bus_data_t     r_rd_data;

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_count;

  logic          w_full, w_empty, w_busy;
  logic          w_pending, w_wr, w_rd;
  logic          w_txd, w_stat;
  logic          w_push, w_pop, w_stall, w_complete;
  logic [3:0]    w_cnt4;
  bus_data_t     w_status;
  logic [7:0]    w_head;
  logic          w_unused;

  assign w_unused = ^{wr_data[15:8], addr[0]};

  assign w_full  = (r_count == CNT_FULL);
  assign w_empty = (r_count == '0);
  assign w_busy  = (r_state != S_IDLE);
  assign w_cnt4  = 4'(r_count);
  assign w_head  = r_mem[r_rp];

  assign w_pending = (run != r_done);
  assign w_wr   = (cmd == bus_cmd_write_w) || (cmd == bus_cmd_write_b);
  assign w_rd   = (cmd == bus_cmd_read_w) || (cmd == bus_cmd_read_b);
  assign w_txd  = (addr[15:1] == 15'd0);
  assign w_stat = (addr[15:1] == 15'd1);

  // Full is judged on the registered count, so a pop never frees a slot
  // for a push at the same edge.
  assign w_stall    = w_pending && w_wr && w_txd && w_full;
  assign w_complete = w_pending && !w_stall;
  assign w_push     = w_complete && w_wr && w_txd;

  assign w_status = {8'h00, w_cnt4, 1'b0, w_busy, w_empty, w_full};

  always_comb begin
    w_state_n = r_state;
    w_baud_n  = r_baud + CW'(1);
    w_bit_n   = r_bit;
    w_shift_n = r_shift;
    w_pop     = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        w_baud_n = '0;
        if (!w_empty) begin
          w_pop     = 1'b1;
          w_shift_n = w_head;
          w_state_n = S_START;
        end
      end
      S_START: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n  = '0;
          w_bit_n   = '0;
          w_state_n = S_DATA;
        end
      end
      S_DATA: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n  = '0;
          w_shift_n = {1'b0, r_shift[7:1]};
          if (r_bit == 3'd7) begin
            w_bit_n   = '0;
            w_state_n = S_STOP;
          end else begin
            w_bit_n = r_bit + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (r_baud == BAUD_LAST) begin
          w_baud_n  = '0;
          w_state_n = S_IDLE;
          if (!w_empty) begin
            w_pop     = 1'b1;
            w_shift_n = w_head;
            w_state_n = S_START;
          end
        end
      end
      default: w_state_n = S_IDLE;
    endcase
    // Line is registered from the next state so each level lasts DIV clks
    w_txp_n = 1'b1;
    if (w_state_n == S_START) w_txp_n = 1'b0;
    if (w_state_n == S_DATA)  w_txp_n = w_shift_n[0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_txp   <= 1'b1;
    end else begin
      r_state <= w_state_n;
      r_baud  <= w_baud_n;
      r_bit   <= w_bit_n;
      r_shift <= w_shift_n;
      r_txp   <= w_txp_n;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + AW'(1);
      if (w_pop)  r_rp <= r_rp + AW'(1);
      if (w_push && !w_pop) r_count <= r_count + (AW + 1)'(1);
      if (w_pop && !w_push) r_count <= r_count - (AW + 1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && w_push) r_mem[r_wp] <= wr_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_done    <= 1'b0;
      r_rd_data <= '0;
    end else if (w_complete) begin
      r_done    <= ~r_done;
      r_rd_data <= (w_rd && w_stat) ? w_status : '0;
    end
  end

  assign rd_data  = r_rd_data;
  assign done     = r_done;
  assign uart_txp = r_txp;

endmodule
